// File: rtl/extensor_parametrizado_if.sv
// Producer/consumer handshake bundle for the immediate extender.
// The extender takes the slave side; whoever drives entrada and consumes saida takes master.
interface extensor_parametrizado_if #(
  parameter int LARGURA_ENTRADA = 2,
  parameter int LARGURA_SAIDA   = 8,
  parameter int PROFUNDIDADE    = 2
);
  localparam int OCW = $clog2(PROFUNDIDADE + 1);

  logic [LARGURA_ENTRADA-1:0] entrada;
  logic [1:0]                 modo;
  logic                       entrada_valida;
  logic                       entrada_pronta;
  logic [LARGURA_SAIDA-1:0]   saida;
  logic                       saida_valida;
  logic                       saida_pronta;
  logic [OCW-1:0]             ocupacao;

  modport slave (
    input  entrada, modo, entrada_valida, saida_pronta,
    output entrada_pronta, saida, saida_valida, ocupacao
  );

  modport master (
    output entrada, modo, entrada_valida, saida_pronta,
    input  entrada_pronta, saida, saida_valida, ocupacao
  );
endinterface

// File: rtl/extensor_parametrizado.sv
// Immediate-field extender (sign / zero / branch offset / upper) feeding a small FIFO.
// The word is converted when it is pushed; the buffer only stores finished words.
//
//   state   | meaning
//   VAZIO   | no words buffered, saida forced to 0
//   PARCIAL | 0 < ocupacao < PROFUNDIDADE, push and pop both allowed
//   CHEIO   | ocupacao = PROFUNDIDADE, producer is stalled
module extensor_parametrizado #(
  parameter int LARGURA_ENTRADA = 2,
  parameter int LARGURA_SAIDA   = 8,
  parameter int PROFUNDIDADE    = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  extensor_parametrizado_if.slave     bus
);
  localparam int LE  = LARGURA_ENTRADA;
  localparam int LS  = LARGURA_SAIDA;
  localparam int PW  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int OCW = $clog2(PROFUNDIDADE + 1);
  localparam logic [PW-1:0]  ULTIMO = PW'(PROFUNDIDADE - 1);
  localparam logic [OCW-1:0] CHEIO_N = OCW'(PROFUNDIDADE);

  typedef enum logic [1:0] {VAZIO, PARCIAL, CHEIO} estado_t;

  estado_t         estado_q, estado_d;
  logic [OCW-1:0]  ocup_q, ocup_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [LS-1:0]   mem_q [PROFUNDIDADE];

  logic [LS-1:0]   sinal;
  logic [LS-1:0]   estendido;
  logic            pronta, valido, push, pop;
  logic [LS-1:0]   saida;

  // Non-power-of-two depths need an explicit wrap rather than natural overflow.
  function automatic logic [PW-1:0] prox(input logic [PW-1:0] p);
    return (p == ULTIMO) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    sinal     = {{(LS-LE){bus.entrada[LE-1]}}, bus.entrada};
    estendido = '0;
    case (bus.modo)
      2'b00:   estendido = sinal;
      2'b01:   estendido = {{(LS-LE){1'b0}}, bus.entrada};
      2'b10:   estendido = sinal << 1;
      default: estendido = {bus.entrada, {(LS-LE){1'b0}}};
    endcase
  end

  always_comb begin
    pronta   = resetn && (estado_q != CHEIO);
    valido   = (estado_q != VAZIO);
    push     = bus.entrada_valida && pronta;
    pop      = valido && bus.saida_pronta;
    saida    = valido ? mem_q[rd_q] : '0;
    ocup_d   = ocup_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    estado_d = estado_q;
    if (push) wr_d = prox(wr_q);
    if (pop)  rd_d = prox(rd_q);
    case ({push, pop})
      2'b10:   ocup_d = ocup_q + OCW'(1);
      2'b01:   ocup_d = ocup_q - OCW'(1);
      default: ocup_d = ocup_q;
    endcase
    if (ocup_d == '0)          estado_d = VAZIO;
    else if (ocup_d == CHEIO_N) estado_d = CHEIO;
    else                       estado_d = PARCIAL;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      estado_q <= VAZIO;
      ocup_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      estado_q <= estado_d;
      ocup_q   <= ocup_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Storage needs no reset: anything stale is masked while the buffer is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= estendido;
  end

  assign bus.entrada_pronta = pronta;
  assign bus.saida_valida   = valido;
  assign bus.saida          = saida;
  assign bus.ocupacao       = ocup_q;
endmodule

// File: doc/extensor_parametrizado.md
EXTENSOR_PARAMETRIZADO -- requirements
Module: extensor_parametrizado

Interface
REQ-001 SHALL have parameter LARGURA_ENTRADA, default 2, immediate field width (>=1).
REQ-002 SHALL have parameter LARGURA_SAIDA, default 8, extended word width (>= LARGURA_ENTRADA+1).
REQ-003 SHALL have parameter PROFUNDIDADE, default 2, output buffer entries (>=1).
REQ-004 SHALL have: clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have: resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have: entrada  input  LARGURA_ENTRADA  immediate field to extend.
REQ-007 SHALL have: modo  input  2  extension mode, sampled with entrada.
REQ-008 SHALL have: entrada_valida  input  1  producer offers entrada/modo.
REQ-009 SHALL have: entrada_pronta  output  1  block can accept this cycle.
REQ-010 SHALL have: saida  output  LARGURA_SAIDA  extended word at buffer head.
REQ-011 SHALL have: saida_valida  output  1  saida holds a valid word.
REQ-012 SHALL have: saida_pronta  input  1  consumer takes saida this cycle.
REQ-013 SHALL have: ocupacao  output  clog2(PROFUNDIDADE+1)  entries currently buffered.

Function
REQ-014 SHALL accept (push) on a rising edge iff entrada_valida=1 and entrada_pronta=1.
REQ-015 SHALL release (pop) on a rising edge iff saida_valida=1 and saida_pronta=1.
REQ-016 SHALL compute the extended word at push time and store it in buffer; conversion is not redone at pop.
REQ-017 modo 00 (sign): all bits above LARGURA_ENTRADA-1 SHALL equal entrada[MSB] (full replication, not a fixed constant).
REQ-018 modo 01 (zero): upper bits SHALL be 0.
REQ-019 modo 10 (branch offset): SHALL be the sign-extended value shifted left 1, bit 0 = 0, MSB overflow discarded.
REQ-020 modo 11 (upper): entrada SHALL occupy saida[LARGURA_SAIDA-1 -: LARGURA_ENTRADA], all lower bits 0.
REQ-021 SHALL be FIFO-ordered: words leave in push order.
REQ-022 Latency: word pushed into an empty buffer SHALL appear on saida with saida_valida=1 in the cycle after the push edge; no combinational entrada-to-saida path.
REQ-023 SHALL track states VAZIO (ocupacao=0), PARCIAL (0<ocupacao<PROFUNDIDADE), CHEIO (ocupacao=PROFUNDIDADE).
REQ-024 Transitions: push-only +1, pop-only -1, push+pop same edge ocupacao unchanged, neither unchanged.
REQ-025 entrada_pronta SHALL be 1 iff resetn=1 and state != CHEIO; no accept-while-full even if saida_pronta=1.
REQ-026 saida_valida SHALL be 1 iff state != VAZIO.
REQ-027 saida SHALL be 0 whenever saida_valida=0.
REQ-028 Simultaneous push+pop in PARCIAL (or VAZIO->impossible pop) SHALL advance head and write tail without loss or duplication.
REQ-029 Read/write pointers SHALL wrap modulo PROFUNDIDADE, correct for non-power-of-two depth.
REQ-030 saida and saida_valida SHALL hold stable while saida_valida=1 and saida_pronta=0.
REQ-031 entrada value SHALL be ignored when no push occurs.

Reset
REQ-032 resetn=0 SHALL immediately, without clock edge, force ocupacao=0, pointers=0, state VAZIO, saida_valida=0, saida=0, entrada_pronta=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered words; no word buffered before reset appears after.
REQ-034 First push SHALL be possible on the first rising edge after resetn returns to 1.

Verification (LARGURA_ENTRADA=2, LARGURA_SAIDA=8, PROFUNDIDADE=2, saida_pronta=1 unless stated)
REQ-035 modo 00: entrada 2'b10 -> saida 8'hFE next cycle; 2'b11 -> 8'hFF; 2'b01 -> 8'h01; 2'b00 -> 8'h00.
REQ-036 entrada 2'b10: modo 01 -> 8'h02; modo 10 -> 8'hFC; modo 11 -> 8'h80; entrada 2'b01 modo 10 -> 8'h02.
REQ-037 saida_pronta=0, offer 2'b10, 2'b11, 2'b01 modo 00 back-to-back -> first two accepted, ocupacao=2, entrada_pronta=0, third held; raise saida_pronta -> saida sequence FE, FF, 01, saida_valida drops after last.
REQ-038 ocupacao=1, push 2'b01 and pop same edge -> ocupacao stays 1, saida shows new 8'h01 next cycle; repeat 5 times -> pointers wrap, no loss.
REQ-039 ocupacao=2, drop resetn between edges -> saida_valida=0, saida=8'h00, ocupacao=0, entrada_pronta=0 immediately; release resetn -> empty, prior words never appear.
REQ-040 Parameter sweep LARGURA_ENTRADA=5, LARGURA_SAIDA=16, PROFUNDIDADE=3: entrada 5'b10000 modo 00 -> 16'hFFF0; modo 11 -> 16'h8000; 3-entry fill/drain preserves order.
